// File: rtl/gametank_loader_pkg.sv
// GameTank ROM loader shared types and constants.
// Header magic, error codes and loader state encoding.
package gametank_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_MAGIC = 2'd1;
  localparam logic [1:0] ERR_SIZE  = 2'd2;
  localparam logic [1:0] ERR_SHORT = 2'd3;

  localparam logic [7:0] MAGIC0 = 8'h47;
  localparam logic [7:0] MAGIC1 = 8'h54;
  localparam logic [7:0] MAGIC2 = 8'h52;
  localparam logic [7:0] MAGIC3 = 8'h1A;

  localparam int HDR_LEN    = 16;
  localparam int UNIT_BYTES = 4096;

  function automatic logic [7:0] magic_byte(
    input logic [1:0] i
  );
    logic [7:0] m;
    case (i)
      2'd0:    m = MAGIC0;
      2'd1:    m = MAGIC1;
      2'd2:    m = MAGIC2;
      default: m = MAGIC3;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/loader_byte_fifo.sv
// Small synchronous byte FIFO buffering payload ahead of the write port.
// Combinational head read; flush empties it on the next edge.
module loader_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign dout   = r_mem[r_rp];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wp] <= din;
  end

endmodule

// File: rtl/gametank_rom_loader.sv
// Parses the GameTank image header from the ROM feeder and streams
// the payload into cartridge memory over a req/ack write port.
module gametank_rom_loader
  import gametank_loader_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int MEM_BASE   = 0,
  parameter int MAX_UNITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic [7:0]        in_data,
  input  logic              in_strobe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              loading,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [7:0]        rom_units,
  output logic [7:0]        mapper
);

  state_t            r_state;
  logic [3:0]        r_hdr_cnt;
  logic [ADDR_W-1:0] r_rx_cnt;
  logic [ADDR_W-1:0] r_wr_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_req;
  logic              r_seen_low;
  logic              r_loading;
  logic              r_done;
  logic              r_error;
  logic [1:0]        r_err;
  logic [7:0]        r_units;
  logic [7:0]        r_mapper;

  logic [ADDR_W-1:0] w_total;
  logic [7:0]        w_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_pld;
  logic              w_more;
  logic              w_take;
  logic              w_ovf;
  logic              w_push;
  logic              w_pop;
  logic              w_bad_size;
  logic              w_last_ack;
  logic              w_restart;
  logic [1:0]        w_fail;

  assign w_total    = ADDR_W'(r_units) * ADDR_W'(UNIT_BYTES);
  assign w_pld      = (r_state == S_PAYLOAD);
  assign w_more     = (r_rx_cnt != w_total);
  assign w_pop      = w_pld && !w_empty && !r_req;
  assign w_take     = w_pld && in_strobe && dl_active && w_more;
  assign w_ovf      = w_take && w_full && !w_pop;
  assign w_push     = w_take && !w_ovf;
  assign w_bad_size = (r_units == 8'd0) || (r_units > 8'(MAX_UNITS));
  assign w_last_ack = r_req && mem_ack && (r_wr_idx == w_total);
  assign w_restart  = dl_active && (r_state == S_IDLE || r_seen_low);

  always_comb begin
    w_fail = ERR_NONE;
    if (r_state == S_HEADER) begin
      if (!dl_active)
        w_fail = ERR_SHORT;
      else if (in_strobe && r_hdr_cnt[3:2] == 2'd0 &&
               in_data != magic_byte(r_hdr_cnt[1:0]))
        w_fail = ERR_MAGIC;
      else if (in_strobe && w_bad_size &&
               r_hdr_cnt == 4'(HDR_LEN - 1))
        w_fail = ERR_SIZE;
    end else if (w_pld && ((!dl_active && w_more) || w_ovf)) begin
      w_fail = ERR_SHORT;
    end
  end

  loader_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (!w_pld),
    .din     (in_data),
    .dout    (w_dout),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_hdr_cnt  <= '0;
      r_rx_cnt   <= '0;
      r_wr_idx   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_req      <= 1'b0;
      r_seen_low <= 1'b0;
      r_loading  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err      <= ERR_NONE;
      r_units    <= '0;
      r_mapper   <= '0;
    end else begin
      if (w_pop) begin
        r_req    <= 1'b1;
        r_addr   <= ADDR_W'(MEM_BASE) + r_wr_idx;
        r_wdata  <= w_dout;
        r_wr_idx <= r_wr_idx + 1'b1;
      end else if (r_req && mem_ack) begin
        r_req <= 1'b0;
      end
      if (w_push) r_rx_cnt <= r_rx_cnt + 1'b1;

      // a failure abandons any outstanding write
      if (w_fail != ERR_NONE) begin
        r_state    <= S_ERROR;
        r_error    <= 1'b1;
        r_err      <= w_fail;
        r_loading  <= 1'b0;
        r_req      <= 1'b0;
        r_seen_low <= 1'b0;
      end else begin
        unique case (r_state)
          S_HEADER: begin
            if (in_strobe) begin
              r_hdr_cnt <= r_hdr_cnt + 1'b1;
              if (r_hdr_cnt == 4'd4) r_units  <= in_data;
              if (r_hdr_cnt == 4'd5) r_mapper <= in_data;
              if (r_hdr_cnt == 4'(HDR_LEN - 1))
                r_state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (w_last_ack) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_loading <= 1'b0;
            end
          end
          default: begin
            if (!dl_active) r_seen_low <= 1'b1;
            if (w_restart) begin
              r_state    <= S_HEADER;
              r_loading  <= 1'b1;
              r_done     <= 1'b0;
              r_error    <= 1'b0;
              r_err      <= ERR_NONE;
              r_hdr_cnt  <= '0;
              r_rx_cnt   <= '0;
              r_wr_idx   <= '0;
              r_seen_low <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_req   = r_req;
  assign loading   = r_loading;
  assign done      = r_done;
  assign error     = r_error;
  assign err_code  = r_err;
  assign rom_units = r_units;
  assign mapper    = r_mapper;

endmodule

// File: tb/tb_gametank_rom_loader.sv
// Randomized bench for gametank_rom_loader with a memory responder
// and an expected-image scoreboard.
module tb_gametank_rom_loader;

  localparam int AW    = 22;
  localparam int BASE  = 0;
  localparam int MAXU  = 8;
  localparam int DEPTH = 4;
  localparam logic [31:0] MAGIC_W = 32'h4754521A;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          dl_active = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_strobe = 1'b0;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_req;
  logic          loading;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [7:0]    rom_units;
  logic [7:0]    mapper;

  always #5 clk = ~clk;

  gametank_rom_loader #(
    .ADDR_W     (AW),
    .MEM_BASE   (BASE),
    .MAX_UNITS  (MAXU),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dl_active (dl_active),
    .in_data   (in_data),
    .in_strobe (in_strobe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .loading   (loading),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .rom_units (rom_units),
    .mapper    (mapper)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] hdr [16];
  logic [7:0] pay [32768];
  int wr_n     = 0;
  int req_cyc  = 0;
  int ack_dly  = 0;
  int wait_cnt = 0;
  bit ack_rnd  = 1'b0;

  // memory model: acks after ack_dly cycles, scores every accepted write
  initial begin : responder
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        req_cyc++;
        if (wait_cnt >= ack_dly) begin
          chk($sformatf("write%0d", wr_n), {mem_addr, mem_wdata},
              {AW'(BASE + wr_n), pay[wr_n % 32768]});
          wr_n++;
          wait_cnt = 0;
          mem_ack = 1'b1;
          if (ack_rnd) ack_dly = $urandom_range(0, 1);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  function automatic int hdr_code(input int upto);
    for (int j = 0; j < 4 && j <= upto; j++)
      if (hdr[j] != MAGIC_W[31-8*j -: 8]) return 1;
    if (upto == 15 && (hdr[4] == 8'd0 || hdr[4] > 8'(MAXU))) return 2;
    return 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] b);
    in_data = b;
    in_strobe = 1'b1;
    @(negedge clk);
    in_strobe = 1'b0;
  endtask

  task automatic start_load();
    dl_active = 1'b0;
    tick(2);
    wr_n = 0;
    req_cyc = 0;
    wait_cnt = 0;
    dl_active = 1'b1;
    tick(2);
    chk("start", {loading, done, error, err_code}, 5'b10000);
  endtask

  task automatic send_hdr(input int units, input int bad_idx,
                          input logic [7:0] bad_val, input int gap);
    for (int i = 0; i < 16; i++) hdr[i] = 8'($urandom);
    for (int j = 0; j < 4; j++) hdr[j] = MAGIC_W[31-8*j -: 8];
    hdr[4] = 8'(units);
    if (bad_idx >= 0) hdr[bad_idx] = bad_val;
    start_load();
    for (int i = 0; i < 16; i++) begin
      int c;
      strobe(hdr[i]);
      c = hdr_code(i);
      chk($sformatf("hdr%0d", i), {error, err_code}, {c != 0, 2'(c)});
      tick(gap - 1);
    end
  endtask

  task automatic send_pay(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      strobe(pay[i]);
      tick(gap - 1);
    end
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (!done && !error && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic chk_bad_hdr(input string tag);
    tick(8);
    chk({tag, "_noreq"}, req_cyc, 0);
    chk({tag, "_nodone"}, {done, loading}, 2'b00);
  endtask

  task automatic chk_good_end(input string tag, input int units);
    wait_end(100);
    chk({tag, "_flags"}, {done, error, err_code, loading}, 5'b10000);
    chk({tag, "_writes"}, wr_n, units * 4096);
    chk({tag, "_units"}, rom_units, units);
    chk({tag, "_mapper"}, mapper, hdr[5]);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int idx;
    int u;
    int k;
    logic [7:0] m;
    for (int i = 0; i < 32768; i++) pay[i] = 8'($urandom);
    tick(2);
    chk("reset", {mem_req, loading, done, error, err_code, rom_units,
                  mapper, mem_addr, mem_wdata}, 0);
    reset_n = 1'b1;
    tick(2);
    chk("idle", {loading, mem_req, done, error}, 0);

    send_hdr(3, 2, 8'h00, 4);
    chk_bad_hdr("magic2");
    idx = $urandom_range(0, 3);
    m = MAGIC_W[31-8*idx -: 8];
    send_hdr(5, idx, m ^ 8'($urandom_range(1, 255)), 3);
    chk_bad_hdr("magicr");

    send_hdr(0, -1, 8'h00, 4);
    chk_bad_hdr("size0");
    chk("size0_units", rom_units, 0);
    send_hdr(9, -1, 8'h00, 4);
    chk_bad_hdr("size9");
    chk("size9_units", rom_units, 9);
    u = $urandom_range(10, 255);
    send_hdr(u, -1, 8'h00, 2);
    chk_bad_hdr("sizer");

    ack_dly = 0;
    send_hdr(7, -1, 8'h00, 2);
    send_pay(28672, 2);
    chk_good_end("full7", 7);

    ack_dly = 20;
    send_hdr(1, -1, 8'h00, 4);
    for (int i = 1; i <= 8; i++) begin
      strobe(pay[i-1]);
      chk($sformatf("ovf_b%0d", i), error, i >= 6);
      tick(3);
    end
    chk("ovf_code", {error, err_code, mem_req}, 4'b1110);
    chk("ovf_writes", wr_n, 0);

    ack_dly = 0;
    send_hdr(2, -1, 8'h00, 4);
    send_pay(100, 4);
    dl_active = 1'b0;
    tick(1);
    chk("drop", {error, err_code, mem_req, done}, 5'b11100);
    chk("drop_writes", wr_n, 100);

    ack_rnd = 1'b1;
    send_hdr(1, -1, 8'h00, 3);
    send_pay(4096, 3);
    chk_good_end("reload", 1);
    ack_rnd = 1'b0;

    ack_dly = 3;
    send_hdr(1, -1, 8'h00, 4);
    send_pay(20, 4);
    k = 0;
    while (!mem_req && k < 50) begin
      tick(1);
      k++;
    end
    chk("rst_req", mem_req, 1);
    #2 reset_n = 1'b0;
    #1 chk("rst_async", {mem_req, loading, done, error, err_code,
                         rom_units, mapper, mem_addr, mem_wdata}, 0);
    @(negedge clk);
    dl_active = 1'b0;
    reset_n = 1'b1;
    tick(1);
    chk("rst_idle", {loading, mem_req}, 0);
    ack_dly = 0;
    send_hdr(2, -1, 8'h00, 4);
    send_pay(40, 4);
    dl_active = 1'b0;
    tick(1);
    chk("rst_reload", {error, err_code}, 3'b111);
    chk("rst_writes", wr_n, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
